// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared state/phase encodings and sync header defaults for the frame streamer
//
// Purpose: one place for the streamer FSM encoding, the byte-phase encoding and
// the default sync header bytes that the PC-side capture decoder also expects.
// Ports: none (package).
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FETCH,
    ST_CAPTURE
  } state_t;

  typedef enum logic [2:0] {
    PH_SYNC0,
    PH_SYNC1,
    PH_HI,
    PH_LO,
    PH_CSUM
  } phase_t;

  localparam logic [7:0] SYNC0_DEF = 8'hAA;
  localparam logic [7:0] SYNC1_DEF = 8'h55;

endpackage

// File: rtl/uart_byte_issuer.sv
// rtl/uart_byte_issuer.sv - ISSUE/WAIT_ACK/WAIT_DONE handshake for one byte into uart_tx
//
// Purpose: takes one byte per byte_req, presents it to uart_tx as a single
// tx_valid pulse once the transmitter is idle, then follows busy high and low
// and reports completion on byte_ack.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   byte_req, byte_in  load a byte; accepted when idle or in the byte_ack cycle
//   cancel             drop a byte still waiting in ISSUE (never one already pulsed)
//   tx_busy            uart_tx busy
//   tx_data, tx_valid  to uart_tx data_in / data_valid
//   byte_ack           one cycle: the current byte has left the transmitter
//   issuing            byte is waiting in ISSUE (nothing handed over yet)
module uart_byte_issuer
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_req,
  input  logic [7:0] byte_in,
  input  logic       cancel,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       byte_ack,
  output logic       issuing
);

  state_t     state, state_nxt;
  logic [7:0] byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      byte_q <= 8'h00;
    end else begin
      state <= state_nxt;
      if (byte_req) byte_q <= byte_in;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    byte_ack  = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (cancel) begin
          state_nxt = ST_IDLE;
        end else if (!tx_busy) begin
          tx_valid  = 1'b1;
          state_nxt = ST_WAIT_ACK;
        end
      end
      // busy rises one cycle after data_valid, so this always lasts >= 1 cycle
      ST_WAIT_ACK: if (tx_busy) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          byte_ack  = 1'b1;
          // a follow-on byte requested in the ack cycle goes straight to ISSUE
          state_nxt = byte_req ? ST_ISSUE : ST_IDLE;
        end
      end
      default: if (byte_req) state_nxt = ST_ISSUE;
    endcase
  end

  assign tx_data = tx_valid ? byte_q : 8'h00;
  assign issuing = (state == ST_ISSUE);

endmodule

// File: rtl/frame_uart_streamer.sv
// rtl/frame_uart_streamer.sv - streams one frame-buffer frame as sync/pixels/XOR checksum bytes to uart_tx
//
// Purpose: on start sends SYNC0, SYNC1, then every pixel high byte then low
// byte in row-major order, then the XOR of all pixel bytes. abort ends the
// frame at the next byte boundary without a checksum.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        frame start pulse; abort level or pulse
//   rd_en, rd_addr      frame-buffer read strobe and pixel address
//   rd_data             RGB565 pixel, valid one cycle after rd_en
//   tx_data, tx_valid   to uart_tx
//   tx_busy             from uart_tx
//   active, done        frame in progress; one-cycle end-of-frame pulse
//
// ST_ISSUE here means "a byte is owned by uart_byte_issuer"; the issuer holds
// the ISSUE/WAIT_ACK/WAIT_DONE detail.
module frame_uart_streamer
  import cam_pkg::*;
#(
  parameter int          FRAME_W = 160,
  parameter int          FRAME_H = 120,
  parameter int          ADDR_W  = 15,
  parameter logic [7:0]  SYNC0   = SYNC0_DEF,
  parameter logic [7:0]  SYNC1   = SYNC1_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              active,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);

  state_t            state, state_nxt;
  phase_t            phase, phase_nxt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        pix_lo;
  logic [7:0]        csum;
  logic              last_pix;
  logic              abort_pend;
  logic              done_q;

  logic              byte_req, byte_ack, issuing, cancel;
  logic [7:0]        byte_in;
  logic              go_idle, csum_upd, capture;
  logic              abort_now;

  assign active    = (state != ST_IDLE);
  assign abort_now = active && (abort || abort_pend);

  uart_byte_issuer u_issuer (
    .clk      (clk),
    .rst_n    (rst_n),
    .byte_req (byte_req),
    .byte_in  (byte_in),
    .cancel   (cancel),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .byte_ack (byte_ack),
    .issuing  (issuing)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= PH_SYNC0;
      addr       <= '0;
      pix_lo     <= 8'h00;
      csum       <= 8'h00;
      last_pix   <= 1'b0;
      abort_pend <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      done_q <= go_idle;
      if (go_idle)                   abort_pend <= 1'b0;
      else if (active && abort)      abort_pend <= 1'b1;
      if (state == ST_IDLE && start) begin
        addr <= '0;
        csum <= 8'h00;
      end else if (csum_upd) begin
        csum <= csum ^ byte_in;
      end
      if (capture) begin
        pix_lo   <= rd_data[7:0];
        // remembered here because addr itself wraps when the frame fills the address space
        last_pix <= (addr == LAST_ADDR);
        addr     <= addr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    byte_req  = 1'b0;
    byte_in   = 8'h00;
    cancel    = 1'b0;
    rd_en     = 1'b0;
    go_idle   = 1'b0;
    csum_upd  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          byte_req  = 1'b1;
          byte_in   = SYNC0;
          phase_nxt = PH_SYNC0;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort_now && issuing) begin
          cancel  = 1'b1;
          go_idle = 1'b1;
        end else if (byte_ack) begin
          if (abort_now) begin
            go_idle = 1'b1;
          end else begin
            case (phase)
              PH_SYNC0: begin
                byte_req  = 1'b1;
                byte_in   = SYNC1;
                phase_nxt = PH_SYNC1;
              end
              PH_SYNC1: state_nxt = ST_FETCH;
              PH_HI: begin
                byte_req  = 1'b1;
                byte_in   = pix_lo;
                csum_upd  = 1'b1;
                phase_nxt = PH_LO;
              end
              PH_LO: begin
                if (last_pix) begin
                  byte_req  = 1'b1;
                  byte_in   = csum;
                  phase_nxt = PH_CSUM;
                end else begin
                  state_nxt = ST_FETCH;
                end
              end
              default: go_idle = 1'b1;
            endcase
          end
        end
      end
      ST_FETCH: begin
        if (abort_now) begin
          go_idle = 1'b1;
        end else begin
          rd_en     = 1'b1;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (abort_now) begin
          go_idle = 1'b1;
        end else begin
          capture   = 1'b1;
          byte_req  = 1'b1;
          byte_in   = rd_data[15:8];
          csum_upd  = 1'b1;
          phase_nxt = PH_HI;
          state_nxt = ST_ISSUE;
        end
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) state_nxt = ST_IDLE;
  end

  assign rd_addr = addr;
  assign done    = done_q;

endmodule

// File: doc/frame_uart_streamer.md
# frame_uart_streamer

Reads one captured frame out of the frame buffer and serialises it as a framed byte stream into the UART transmitter. It sits between the frame-buffer read port and `uart_tx` and drives that block's `data_in`/`data_valid` and monitors its `busy`. One `start` pulse sends one frame: a two-byte sync header, then every pixel as high byte followed by low byte, then a one-byte XOR checksum.

## Interface
- `FRAME_W`, 160, pixels per line
- `FRAME_H`, 120, lines per frame
- `ADDR_W`, 15, frame-buffer address width; must satisfy FRAME_W*FRAME_H <= 2^ADDR_W
- `SYNC0`, 8'hAA, first header byte
- `SYNC1`, 8'h55, second header byte
- `clk`  in  1  system clock, shared with `uart_tx`
- `rst_n`  in  1  reset; one clock, asynchronous active-low reset
- `start`  in  1  one-cycle pulse; begins a frame when idle
- `abort`  in  1  level or pulse; stops the frame at the next byte boundary
- `rd_en`  out  1  frame-buffer read strobe
- `rd_addr`  out  ADDR_W  pixel address, row-major, 0 .. FRAME_W*FRAME_H-1
- `rd_data`  in  16  RGB565 pixel, valid exactly one cycle after `rd_en`
- `tx_data`  out  8  byte to `uart_tx.data_in`
- `tx_valid`  out  1  one-cycle pulse to `uart_tx.data_valid`
- `tx_busy`  in  1  from `uart_tx.busy`
- `active`  out  1  high from accepted `start` until return to IDLE
- `done`  out  1  one-cycle pulse when the checksum byte completes or an abort finishes

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, FETCH, CAPTURE.
- Byte phases in order: SYNC0, SYNC1, then per pixel HI (`rd_data[15:8]`) and LO (`rd_data[7:0]`), then CSUM.
- IDLE: `start`=1 latches phase=SYNC0, pixel address=0, checksum=0, and sets `active`=1 -> ISSUE. `start` is ignored in every other state.
- ISSUE: if `tx_busy`=0, assert `tx_valid` for one cycle with the current phase byte -> WAIT_ACK. Otherwise hold.
- WAIT_ACK: hold until `tx_busy`=1 -> WAIT_DONE.
- WAIT_DONE: hold until `tx_busy`=0, then advance the phase:
  - SYNC1 or LO -> FETCH.
  - CSUM or abort pending -> IDLE, with `done` pulsed.
  - Otherwise -> ISSUE.
- FETCH: `rd_en`=1, `rd_addr`=pixel address -> CAPTURE.
- CAPTURE: register `rd_data` into the pixel register and increment the address -> ISSUE with phase HI.
- After the LO byte of the last pixel (address FRAME_W*FRAME_H-1), the phase goes to CSUM instead of FETCH.
- Checksum: 8-bit XOR of every HI and LO byte. It is updated when each HI/LO byte is issued. Header bytes are excluded.
- Abort: sampled any cycle while `active`, latched as pending. It never truncates a byte already handed to `uart_tx`. The abort takes effect in WAIT_DONE, or immediately in ISSUE/FETCH/CAPTURE (-> IDLE, `done` pulse). No checksum is sent on abort.
- Width rules: the pixel counter is ADDR_W bits and never wraps within a frame. The checksum register is 8 bits.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `rd_en`=0, `rd_addr`=0, `active`=0, `done`=0. State is IDLE and the abort latch is clear.
- `start` at cycle 0 -> `tx_valid`=1 with SYNC0 at cycle 1 (with `tx_busy`=0).
- `uart_tx` raises `busy` one cycle after `data_valid`. WAIT_ACK therefore spans at least one cycle, so a second pulse is never issued before `busy` rises.
- Gap between bytes: `busy` falls at cycle n -> next `tx_valid` at n+1 for header/HI/CSUM bytes, and at n+3 for a new pixel's HI (FETCH and CAPTURE add two cycles).
- `done` is asserted in the same cycle that `active` falls.
- Frame length: 2 + 2*FRAME_W*FRAME_H + 1 bytes.
- `rst_n` low mid-frame: all outputs return to reset values immediately. No partial checksum is emitted afterwards.

## Structure
- Shared package `cam_pkg`: the state encoding and the SYNC0/SYNC1 defaults, also used by the PC-side capture decoder documentation.
- One natural sub-module, `uart_byte_issuer`, owns the ISSUE/WAIT_ACK/WAIT_DONE handshake. It exposes byte_req/byte_ack to the streamer FSM.
- `uart_tx` is instantiated by the top level, not inside this block.

## Test plan
- FRAME_W=2, FRAME_H=2, memory {16'h1234, 16'hABCD, 16'h00FF, 16'h8001}, `start` -> bytes AA 55 12 34 AB CD 00 FF 80 01 then checksum; `done` pulses once after the final byte.
- Same frame with real `uart_tx` (CLK_FREQ/BAUD_RATE=16) -> decoded serial line matches the byte list, with exactly one `tx_valid` per byte.
- `start` pulsed again mid-frame -> ignored; byte count stays 11.
- `abort` asserted during the second pixel's HI transmission -> that byte completes, no further `tx_valid`, `done` pulses, no checksum byte.
- `tx_busy` held high artificially for 100 cycles in ISSUE -> no `tx_valid` until release, then SYNC0 on the next cycle.
- `rst_n` low during pixel 1 LO, then `start` -> fresh frame beginning AA 55 12 ... with checksum reset.
